mc_mips_core: RTL and testbench
===============================

Name: mc_mips_core

Overview:
- Self-contained multicycle MIPS core: main-control FSM, ALU decoder, and a 32-bit multicycle datapath with a single shared instruction/data memory port.
- Successor to the bare multicycle datapath. Adds a memory-ready handshake (variable-latency memory), a parametrised reset vector, and extra instructions: bne, addi, andi, ori (zero-extended), j.
- Also adds an illegal-opcode flag.
- Sits between the top-level and the unified memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, register-file depth. Must be 16 or 32; register indices are taken modulo NREGS.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- adr, output, 32, memory byte address: PC in FETCH, ALUOut otherwise.
- writedata, output, 32, store data (B register).
- memread, output, 1, read request.
- memwrite, output, 1, write request.
- readdata, input, 32, memory read data; valid when memready=1.
- memready, input, 1, memory completes the current request this cycle.
- pc, output, 32, current architectural PC.
- state, output, 4, FSM state encoding (debug).
- illegal, output, 1, sticky; set on an undefined opcode/funct.

Behaviour:
- Reset (asynchronous, active-high):
  - pc=RESET_PC, state=FETCH, illegal=0, all registers and IR/A/B/ALUOut/Data cleared.
  - memread=0 and memwrite=0 while reset is asserted; memread=1 on the first FETCH cycle after release.
  - Reset mid-instruction aborts it; a pending memory request is dropped.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEX=8, IEX=9, IWB=10, JEX=11.
- FETCH: adr=pc, memread=1. Stays in FETCH while memready=0. On memready: IR<=readdata, pc<=pc+4, next DECODE.
- DECODE:
  - A<=rf[rs], B<=rf[rt], ALUOut<=pc+(signimm<<2).
  - Dispatch: lw/sw->MEMADR, R-type->REX, beq/bne->BEX, addi/andi/ori->IEX, j->JEX.
  - Undefined opcode: illegal<=1, next FETCH (executes as nop).
- MEMADR: ALUOut<=A+signimm. lw->MEMRD, sw->MEMWR.
- MEMRD: adr=ALUOut, memread=1. Holds until memready; then Data<=readdata, next MEMWB.
- MEMWB: rf[rt]<=Data, next FETCH.
- MEMWR: adr=ALUOut, memwrite=1, writedata=B. Holds until memready, then FETCH.
- REX: ALUOut<=A op B.
  - funct add=0x20, sub=0x22, and=0x24, or=0x25, slt=0x2A.
  - slt is signed; result 1 or 0.
  - Other funct: illegal<=1, no writeback, next FETCH.
  - Otherwise next RWB.
- RWB: rf[rd]<=ALUOut, next FETCH.
- BEX: compute A-B. If (beq and zero) or (bne and !zero), pc<=ALUOut (branch target from DECODE). Next FETCH.
- IEX:
  - addi: A+signimm.
  - andi/ori: A op {16'b0, imm}.
  - ALUOut<=result, next IWB.
- IWB: rf[rt]<=ALUOut, next FETCH.
- JEX: pc<={pc[31:28], instr[25:0], 2'b00}, next FETCH.
- Arithmetic: 32-bit wrap, no overflow trap. Register 0 always reads 0 and writes to it are discarded.
- Register file: 2 asynchronous read ports, 1 synchronous write port. Read of a register being written in the same cycle returns the old value.
- memread and memwrite are never both 1. Both are 0 in every state other than FETCH/MEMRD/MEMWR.
- Cycle counts at zero wait: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3. Each wait cycle adds 1 to FETCH, MEMRD or MEMWR.
- Opcodes: R=0x00, j=0x02, beq=0x04, bne=0x05, addi=0x08, andi=0x0C, ori=0x0D, lw=0x23, sw=0x2B.

Test Plan:
- Reset with RESET_PC=32'h0000_0100, memready tied 1 -> first adr=0x100 with memread=1; pc=0x104 after the first FETCH; state sequence 0,1,...
- addi $2,$0,5; addi $3,$0,12; or $4,$2,$3; sub $5,$3,$2; slt $6,$5,$4 -> $4=13, $5=7, $6=1. Total 20 cycles at zero wait.
- sw $4,84($0) then lw $7,84($0) -> memwrite=1 at adr=84 with writedata=13; $7=13; lw takes 5 cycles.
- memready low for 3 cycles during FETCH and during MEMRD -> state holds, no pc or register change; lw takes 11 cycles; readdata sampled only on the memready cycle.
- beq $2,$2,+2 at 0x10 -> pc=0x1C. bne $2,$2,+2 -> pc=0x14. j 0x40 -> pc=0x100. Each takes 3 cycles.
- Opcode 0x3F, then andi $8,$0,0xFFFF / ori $8,$0,0x8000 -> illegal=1 (sticky), state returns to FETCH; $8=0x0000_8000 (zero-extended). Async reset asserted mid-MEMRD -> immediate return to FETCH with pc=RESET_PC.

Source files
------------

// File: rtl/mc_mips_core.sv
// Multicycle MIPS core: main-control FSM, ALU decode and a 32-bit datapath sharing
// one instruction/data memory port, with a ready handshake for variable-latency memory.
module mc_mips_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic        memread,
  output logic        memwrite,
  input  logic [31:0] readdata,
  input  logic        memready,
  output logic [31:0] pc,
  output logic [3:0]  state,
  output logic        illegal
);
  localparam int RW = $clog2(NREGS);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    REX = 4'd6, RWB = 4'd7, BEX = 4'd8, IEX = 4'd9, IWB = 4'd10, JEX = 4'd11
  } state_t;

  state_t              st, st_nx;
  logic [31:0]         pc_r, ir, a, b, alu_out, mdr;
  logic                illegal_r;
  logic [31:0]         rf [NREGS];
  logic [5:0]          op, funct;
  logic [RW-1:0]       rs, rt, rd;
  logic signed [31:0]  simm;
  logic [31:0]         zimm, i_res, diff;
  logic                op_ok, funct_ok, take;
  logic                we;
  logic [RW-1:0]       wa;
  logic [31:0]         wd;

  function automatic logic [31:0] r_alu(input logic [5:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    case (f)
      F_ADD:   return x + y;
      F_SUB:   return x - y;
      F_AND:   return x & y;
      F_OR:    return x | y;
      F_SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Register indices wrap modulo NREGS by keeping only the low RW bits of each field.
  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign rs       = ir[21 +: RW];
  assign rt       = ir[16 +: RW];
  assign rd       = ir[11 +: RW];
  assign simm     = $signed({{16{ir[15]}}, ir[15:0]});
  assign zimm     = {16'h0000, ir[15:0]};
  assign op_ok    = op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
  assign funct_ok = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign diff     = a - b;
  assign take     = ((op == OP_BEQ) && (diff == 32'd0)) || ((op == OP_BNE) && (diff != 32'd0));

  assign pc        = pc_r;
  assign state     = st;
  assign illegal   = illegal_r;
  assign writedata = b;

  always_comb begin
    i_res = 32'd0;
    case (op)
      OP_ADDI: i_res = a + $unsigned(simm);
      OP_ANDI: i_res = a & zimm;
      OP_ORI:  i_res = a | zimm;
      default: i_res = 32'd0;
    endcase
  end

  always_comb begin
    we = 1'b0;
    wa = rt;
    wd = alu_out;
    case (st)
      MEMWB:   begin we = 1'b1; wa = rt; wd = mdr;     end
      RWB:     begin we = 1'b1; wa = rd; wd = alu_out; end
      IWB:     begin we = 1'b1; wa = rt; wd = alu_out; end
      default: we = 1'b0;
    endcase
  end

  always_comb begin
    st_nx    = st;
    memread  = 1'b0;
    memwrite = 1'b0;
    adr      = alu_out;
    case (st)
      FETCH: begin
        adr     = pc_r;
        memread = 1'b1;
        if (memready) st_nx = DECODE;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW:             st_nx = MEMADR;
          OP_R:                     st_nx = REX;
          OP_BEQ, OP_BNE:           st_nx = BEX;
          OP_ADDI, OP_ANDI, OP_ORI: st_nx = IEX;
          OP_J:                     st_nx = JEX;
          default:                  st_nx = FETCH;
        endcase
      end
      MEMADR: st_nx = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        memread = 1'b1;
        if (memready) st_nx = MEMWB;
      end
      MEMWR: begin
        memwrite = 1'b1;
        if (memready) st_nx = FETCH;
      end
      REX:     st_nx = funct_ok ? RWB : FETCH;
      IEX:     st_nx = IWB;
      default: st_nx = FETCH;
    endcase
    // The FSM already sits in FETCH during reset; keep the bus idle until release.
    if (reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= FETCH;
      pc_r      <= RESET_PC;
      illegal_r <= 1'b0;
      ir        <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      alu_out   <= 32'd0;
      mdr       <= 32'd0;
      for (int i = 0; i < NREGS; i++) rf[i] <= 32'd0;
    end else begin
      st <= st_nx;
      case (st)
        FETCH: if (memready) begin
          ir   <= readdata;
          pc_r <= pc_r + 32'd4;
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc_r + $unsigned(simm <<< 2);
          if (!op_ok) illegal_r <= 1'b1;
        end
        MEMADR: alu_out <= a + $unsigned(simm);
        MEMRD:  if (memready) mdr <= readdata;
        REX: begin
          alu_out <= r_alu(funct, a, b);
          if (!funct_ok) illegal_r <= 1'b1;
        end
        BEX:     if (take) pc_r <= alu_out;
        IEX:     alu_out <= i_res;
        JEX:     pc_r <= {pc_r[31:28], ir[25:0], 2'b00};
        default: ;
      endcase
      // Register 0 is never written, so it reads as zero.
      if (we && (wa != '0)) rf[wa] <= wd;
    end
  end
endmodule

// File: tb/tb_mc_mips_core.sv
// Bench for mc_mips_core: unified memory with programmable wait states and an
// instruction-level reference model of the ISA compared after each program.
module tb_mc_mips_core;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr, writedata, readdata, pc;
  logic        memread, memwrite, memready, illegal;
  logic [3:0]  state;

  mc_mips_core #(.RESET_PC(RPC), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memread(memread),
    .memwrite(memwrite), .readdata(readdata), .memready(memready), .pc(pc),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int inv_bad = 0;

  logic [31:0] mem [1024];
  logic [31:0] junk = 32'hDEAD_BEEF;
  int          wcnt = 0;
  int          wait_n = 0;
  int          wait_fix = 0;
  bit          wait_rand = 0;
  logic [31:0] last_wadr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  // Memory answers a request after wait_n stalled cycles; data is junk while not ready.
  assign memready = (wcnt >= wait_n);
  assign readdata = memready ? mem[adr[11:2]] : junk;

  always @(negedge clk) junk <= $urandom;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt   <= 0;
      wait_n <= wait_rand ? int'($urandom_range(0, 2)) : wait_fix;
    end else if (memread || memwrite) begin
      if (memready) begin
        wcnt   <= 0;
        wait_n <= wait_rand ? int'($urandom_range(0, 2)) : wait_fix;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Reference model state
  logic [31:0] rrf [32];
  logic [31:0] rmem [1024];
  bit          rill;
  int          rcyc;

  function automatic logic [31:0] ei(input logic [5:0] o, input logic [4:0] s,
                                     input logic [4:0] t, input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] ej(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0) rrf[idx] = v;
  endtask

  task automatic iss(input logic [31:0] halt);
    logic [31:0] p, ins, s, z, x, y, ea;
    logic [5:0]  o, f;
    logic [4:0]  rs, rt, rd;
    int          steps;
    for (int i = 0; i < 32; i++) rrf[i] = 32'd0;
    for (int i = 0; i < 1024; i++) rmem[i] = mem[i];
    rill = 0; rcyc = 0; p = RPC; steps = 0;
    while (p != halt && steps < 4000) begin
      ins = rmem[p[11:2]];
      p = p + 32'd4;
      steps++;
      o = ins[31:26]; f = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      s = {{16{ins[15]}}, ins[15:0]};
      z = {16'h0000, ins[15:0]};
      x = rrf[rs]; y = rrf[rt];
      ea = x + s;
      case (o)
        6'h00: begin
          rcyc += 4;
          case (f)
            6'h20: set_reg(rd, x + y);
            6'h22: set_reg(rd, x - y);
            6'h24: set_reg(rd, x & y);
            6'h25: set_reg(rd, x | y);
            6'h2A: set_reg(rd, ($signed(x) < $signed(y)) ? 32'd1 : 32'd0);
            default: begin rill = 1; rcyc -= 1; end
          endcase
        end
        6'h02: begin p = {p[31:28], ins[25:0], 2'b00}; rcyc += 3; end
        6'h04: begin if (x == y) p = p + (s << 2); rcyc += 3; end
        6'h05: begin if (x != y) p = p + (s << 2); rcyc += 3; end
        6'h08: begin set_reg(rt, x + s); rcyc += 4; end
        6'h0C: begin set_reg(rt, x & z); rcyc += 4; end
        6'h0D: begin set_reg(rt, x | z); rcyc += 4; end
        6'h23: begin set_reg(rt, rmem[ea[11:2]]); rcyc += 5; end
        6'h2B: begin rmem[ea[11:2]] = y; rcyc += 4; end
        default: begin rill = 1; rcyc += 2; end
      endcase
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs from just after reset release until the FETCH of the halt word, watching bus rules.
  task automatic run_to(input logic [31:0] halt, input int max, output int cyc,
                        output int waits, output bit tmo);
    logic [3:0]  ps;
    logic [31:0] ppc, wa, wd;
    bit          stall, wr;
    cyc = 0; waits = 0; tmo = 1;
    #1;
    for (int k = 0; k < max; k++) begin
      if (memread && memwrite) inv_bad++;
      if ((memread || memwrite) && !(state == 4'd0 || state == 4'd3 || state == 4'd5)) inv_bad++;
      if (state == 4'd0 && (adr !== pc || memread !== 1'b1)) inv_bad++;
      stall = (memread || memwrite) && !memready;
      if (stall) waits++;
      wr = memwrite && memready;
      wa = adr; wd = writedata; ps = state; ppc = pc;
      @(posedge clk);
      #1;
      cyc++;
      if (wr) begin
        mem[wa[11:2]] = wd;
        last_wadr = wa;
        last_wdata = wd;
      end
      if (stall && (state !== ps || pc !== ppc)) inv_bad++;
      if (state == 4'd0 && pc == halt) begin
        tmo = 0;
        break;
      end
    end
  endtask

  task automatic exec_prog(input logic [31:0] halt, input string name, output int cyc);
    int waits, bad;
    bit tmo;
    iss(halt);
    inv_bad = 0;
    hold_reset();
    run_to(halt, 3000, cyc, waits, tmo);
    ncmp++;
    if (tmo) begin nerr++; $display("FAIL %s halt: not reached, pc=%h want %h", name, pc, halt); end
    for (int i = 0; i < 32; i++) begin
      ncmp++;
      if (dut.rf[i] !== rrf[i]) begin
        nerr++;
        $display("FAIL %s rf[%0d]: got %h want %h", name, i, dut.rf[i], rrf[i]);
      end
    end
    ncmp++;
    if (illegal !== rill) begin nerr++; $display("FAIL %s illegal: got %b want %b", name, illegal, rill); end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== rmem[i]) bad++;
    ncmp++;
    if (bad != 0) begin nerr++; $display("FAIL %s memory: %0d words differ, want 0", name, bad); end
    ncmp++;
    if (cyc != rcyc + waits) begin
      nerr++;
      $display("FAIL %s cycles: got %0d want %0d", name, cyc, rcyc + waits);
    end
    ncmp++;
    if (inv_bad != 0) begin nerr++; $display("FAIL %s bus rules: %0d violations, want 0", name, inv_bad); end
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[64] = ei(6'h08, 0, 2, 16'd5);
    mem[65] = ei(6'h08, 0, 3, 16'd12);
    mem[66] = er(2, 3, 4, 6'h25);
    mem[67] = er(3, 2, 5, 6'h22);
    mem[68] = er(5, 4, 6, 6'h2A);
    mem[69] = ej(32'h114);
  endtask

  task automatic test_reset();
    wait_rand = 0; wait_fix = 0;
    load_prog1();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ncmp++; if (memread !== 1'b0) begin nerr++; $display("FAIL reset memread: got %b want 0", memread); end
    ncmp++; if (memwrite !== 1'b0) begin nerr++; $display("FAIL reset memwrite: got %b want 0", memwrite); end
    ncmp++; if (pc !== RPC) begin nerr++; $display("FAIL reset pc: got %h want %h", pc, RPC); end
    ncmp++; if (state !== 4'd0) begin nerr++; $display("FAIL reset state: got %0d want 0", state); end
    ncmp++; if (illegal !== 1'b0) begin nerr++; $display("FAIL reset illegal: got %b want 0", illegal); end
    reset = 1'b0;
    #1;
    ncmp++; if (memread !== 1'b1) begin nerr++; $display("FAIL first fetch memread: got %b want 1", memread); end
    ncmp++; if (adr !== RPC) begin nerr++; $display("FAIL first fetch adr: got %h want %h", adr, RPC); end
    @(posedge clk); #1;
    ncmp++; if (pc !== RPC + 32'd4) begin nerr++; $display("FAIL pc after fetch: got %h want %h", pc, RPC + 32'd4); end
    ncmp++; if (state !== 4'd1) begin nerr++; $display("FAIL state after fetch: got %0d want 1", state); end
    @(posedge clk); #1;
    ncmp++; if (state !== 4'd9) begin nerr++; $display("FAIL addi dispatch state: got %0d want 9", state); end
  endtask

  task automatic test_alu();
    int cyc;
    wait_rand = 0; wait_fix = 0;
    load_prog1();
    exec_prog(32'h114, "alu", cyc);
    ncmp++; if (dut.rf[4] !== 32'd13) begin nerr++; $display("FAIL alu or: got %h want 13", dut.rf[4]); end
    ncmp++; if (dut.rf[5] !== 32'd7) begin nerr++; $display("FAIL alu sub: got %h want 7", dut.rf[5]); end
    ncmp++; if (dut.rf[6] !== 32'd1) begin nerr++; $display("FAIL alu slt: got %h want 1", dut.rf[6]); end
    ncmp++; if (cyc != 20) begin nerr++; $display("FAIL alu total cycles: got %0d want 20", cyc); end
  endtask

  task automatic test_mem();
    int cyc;
    wait_rand = 0; wait_fix = 0;
    clear_mem();
    mem[64] = ei(6'h08, 0, 4, 16'd13);
    mem[65] = ei(6'h2B, 0, 4, 16'd84);
    mem[66] = ei(6'h23, 0, 7, 16'd84);
    mem[67] = ej(32'h10C);
    exec_prog(32'h10C, "swlw", cyc);
    ncmp++; if (last_wadr !== 32'd84) begin nerr++; $display("FAIL sw adr: got %h want 84", last_wadr); end
    ncmp++; if (last_wdata !== 32'd13) begin nerr++; $display("FAIL sw data: got %h want 13", last_wdata); end
    ncmp++; if (dut.rf[7] !== 32'd13) begin nerr++; $display("FAIL lw value: got %h want 13", dut.rf[7]); end
    ncmp++; if (cyc != 13) begin nerr++; $display("FAIL swlw cycles: got %0d want 13", cyc); end
  endtask

  task automatic test_wait();
    int cyc;
    wait_rand = 0; wait_fix = 3;
    clear_mem();
    mem[21] = 32'hCAFE_F00D;
    mem[64] = ei(6'h23, 0, 7, 16'd84);
    mem[65] = ej(32'h104);
    exec_prog(32'h104, "wait", cyc);
    ncmp++; if (dut.rf[7] !== 32'hCAFE_F00D) begin nerr++; $display("FAIL wait lw: got %h want cafef00d", dut.rf[7]); end
    ncmp++; if (cyc != 11) begin nerr++; $display("FAIL wait lw cycles: got %0d want 11", cyc); end
    wait_fix = 0;
  endtask

  task automatic test_branch();
    int cyc;
    wait_rand = 0; wait_fix = 0;
    clear_mem();
    mem[64] = ei(6'h08, 0, 2, 16'd5);
    mem[65] = ei(6'h08, 0, 10, 16'd1);
    mem[66] = ei(6'h08, 0, 11, 16'd2);
    mem[67] = ei(6'h08, 0, 12, 16'd3);
    mem[68] = ei(6'h04, 2, 2, 16'd2);
    mem[69] = ei(6'h08, 0, 13, 16'd99);
    mem[70] = ei(6'h08, 0, 13, 16'd98);
    mem[71] = ei(6'h05, 2, 2, 16'd2);
    mem[72] = ei(6'h08, 0, 14, 16'd7);
    mem[73] = ej(32'h12C);
    mem[74] = ei(6'h08, 0, 15, 16'd55);
    mem[75] = ej(32'h12C);
    exec_prog(32'h12C, "branch", cyc);
    ncmp++; if (dut.rf[13] !== 32'd0) begin nerr++; $display("FAIL beq skip: got %h want 0", dut.rf[13]); end
    ncmp++; if (dut.rf[14] !== 32'd7) begin nerr++; $display("FAIL bne fallthrough: got %h want 7", dut.rf[14]); end
    ncmp++; if (dut.rf[15] !== 32'd0) begin nerr++; $display("FAIL j skip: got %h want 0", dut.rf[15]); end
    ncmp++; if (cyc != 29) begin nerr++; $display("FAIL branch cycles: got %0d want 29", cyc); end
  endtask

  task automatic test_jump();
    int cyc;
    wait_rand = 0; wait_fix = 0;
    clear_mem();
    mem[64] = ei(6'h08, 16, 16, 16'd1);
    mem[65] = ei(6'h08, 0, 17, 16'd2);
    mem[66] = ei(6'h04, 16, 17, 16'd1);
    mem[67] = ej(32'h100);
    mem[68] = ej(32'h110);
    exec_prog(32'h110, "jump", cyc);
    ncmp++; if (dut.rf[16] !== 32'd2) begin nerr++; $display("FAIL jump loop count: got %h want 2", dut.rf[16]); end
    ncmp++; if (cyc != 25) begin nerr++; $display("FAIL jump cycles: got %0d want 25", cyc); end
  endtask

  task automatic test_illegal();
    int cyc;
    wait_rand = 0; wait_fix = 0;
    clear_mem();
    mem[64] = 32'hFC00_0000;
    mem[65] = ei(6'h0C, 0, 8, 16'hFFFF);
    mem[66] = ei(6'h0D, 0, 8, 16'h8000);
    mem[67] = ej(32'h10C);
    exec_prog(32'h10C, "illegal", cyc);
    ncmp++; if (illegal !== 1'b1) begin nerr++; $display("FAIL illegal sticky: got %b want 1", illegal); end
    ncmp++; if (dut.rf[8] !== 32'h0000_8000) begin nerr++; $display("FAIL ori zero-ext: got %h want 00008000", dut.rf[8]); end
    ncmp++; if (cyc != 10) begin nerr++; $display("FAIL illegal cycles: got %0d want 10", cyc); end
  endtask

  task automatic test_reset_mid();
    int  cyc, waits;
    bit  found, tmo;
    wait_rand = 0; wait_fix = 3;
    clear_mem();
    mem[21] = 32'h1357_9BDF;
    mem[64] = ei(6'h23, 0, 7, 16'd84);
    mem[65] = ej(32'h104);
    hold_reset();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge clk); #1;
      if (state == 4'd3) found = 1;
    end
    ncmp++;
    if (!found) begin nerr++; $display("FAIL midreset: MEMRD not reached, state=%0d want 3", state); end
    #2 reset = 1'b1;
    #1;
    ncmp++; if (state !== 4'd0) begin nerr++; $display("FAIL midreset state: got %0d want 0", state); end
    ncmp++; if (pc !== RPC) begin nerr++; $display("FAIL midreset pc: got %h want %h", pc, RPC); end
    ncmp++; if (memread !== 1'b0) begin nerr++; $display("FAIL midreset memread: got %b want 0", memread); end
    ncmp++; if (dut.rf[7] !== 32'd0) begin nerr++; $display("FAIL midreset rf7: got %h want 0", dut.rf[7]); end
    @(negedge clk);
    reset = 1'b0;
    run_to(32'h104, 200, cyc, waits, tmo);
    ncmp++; if (tmo || cyc != 11) begin nerr++; $display("FAIL restart cycles: got %0d want 11", cyc); end
    ncmp++; if (dut.rf[7] !== 32'h1357_9BDF) begin nerr++; $display("FAIL restart lw: got %h want 13579bdf", dut.rf[7]); end
    wait_fix = 0;
  endtask

  task automatic test_random();
    localparam int N = 24;
    logic [5:0]  fl [5];
    logic [5:0]  badop [4];
    logic [5:0]  f;
    logic [31:0] tgt, ins;
    int          k, cyc;
    fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
    badop[0] = 6'h01; badop[1] = 6'h10; badop[2] = 6'h20; badop[3] = 6'h3F;
    for (int it = 0; it < 8; it++) begin
      clear_mem();
      for (int i = 512; i < 576; i++) mem[i] = $urandom;
      for (int i = 0; i < N; i++) begin
        k = $urandom_range(0, 11);
        case (k)
          0, 1: ins = ei(6'h08, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom));
          2:    ins = ei(6'h0C, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom));
          3:    ins = ei(6'h0D, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom));
          4, 5: begin
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
            ins = er(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), f);
          end
          6:    ins = ei(6'h23, 0, 5'($urandom_range(0, 15)), 16'(32'h800 + 4 * $urandom_range(0, 63)));
          7:    ins = ei(6'h2B, 0, 5'($urandom_range(0, 15)), 16'(32'h800 + 4 * $urandom_range(0, 63)));
          8:    ins = ei(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom_range(0, N - 1 - i)));
          9:    ins = ei(6'h05, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom_range(0, N - 1 - i)));
          10: begin
            tgt = RPC + 32'(4 * $urandom_range(i + 1, N));
            ins = ej(tgt);
          end
          default: ins = {badop[$urandom_range(0, 3)], 26'($urandom)};
        endcase
        mem[64 + i] = ins;
      end
      tgt = RPC + 32'(4 * N);
      mem[64 + N] = ej(tgt);
      wait_rand = (it % 2) == 1;
      exec_prog(tgt, $sformatf("rand%0d", it), cyc);
    end
    wait_rand = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    #1;
    test_reset();
    test_alu();
    test_mem();
    test_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
